// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state codes and constants for the memory-game control unit
package jogo_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 3000;
  localparam int PROFUNDIDADE_MEMORIA  = 16;
  localparam int TIMER_W               = 16;

  // Codes double as the 7-segment debug value
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - 16-bit play-timeout counter, clear has priority over count
module contador_timeout
  import jogo_pkg::*;
#(
  parameter int MAX = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [TIMER_W-1:0] LIMITE = TIMER_W'(MAX - 1);

  logic [TIMER_W-1:0] valor_q;
  logic [TIMER_W-1:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = valor_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim = (valor_q == LIMITE);

endmodule

// File: rtl/controle_jogo_sequencia.sv
// rtl/controle_jogo_sequencia.sv - Moore control unit sequencing the memory-game datapath
module controle_jogo_sequencia
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registrador,
  output logic       registra,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q;
  estado_t estado_d;
  logic    em_espera;
  logic    fim_timer;

  assign em_espera = (estado_q == ESPERA);

  // Timer is held at zero outside ESPERA so every wait starts fresh
  contador_timeout #(
    .MAX(TIMEOUT_CICLOS)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .zera (!em_espera),
    .conta(em_espera),
    .fim  (fim_timer)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d         = INICIAL;
    zera_contador    = 1'b0;
    conta_contador   = 1'b0;
    zera_registrador = 1'b0;
    registra         = 1'b0;
    acertou          = 1'b0;
    errou            = 1'b0;
    timeout          = 1'b0;
    pronto           = 1'b0;
    case (estado_q)
      INICIAL: begin
        estado_d = iniciar ? PREPARA : INICIAL;
      end
      PREPARA: begin
        zera_contador    = 1'b1;
        zera_registrador = 1'b1;
        estado_d         = ESPERA;
      end
      ESPERA: begin
        // A play arriving on the last allowed cycle still counts
        if (jogada_feita)   estado_d = REGISTRA;
        else if (fim_timer) estado_d = FIM_TIMEOUT;
        else                estado_d = ESPERA;
      end
      REGISTRA: begin
        registra = 1'b1;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igual)            estado_d = FIM_ERRO;
        else if (fim_contagem) estado_d = FIM_ACERTO;
        else                   estado_d = PROXIMO;
      end
      PROXIMO: begin
        conta_contador = 1'b1;
        estado_d       = ESPERA;
      end
      FIM_ACERTO: begin
        pronto   = 1'b1;
        acertou  = 1'b1;
        estado_d = iniciar ? PREPARA : FIM_ACERTO;
      end
      FIM_ERRO: begin
        pronto   = 1'b1;
        errou    = 1'b1;
        estado_d = iniciar ? PREPARA : FIM_ERRO;
      end
      FIM_TIMEOUT: begin
        pronto   = 1'b1;
        errou    = 1'b1;
        timeout  = 1'b1;
        estado_d = iniciar ? PREPARA : FIM_TIMEOUT;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_jogo_sequencia.sv
// tb/tb_controle_jogo_sequencia.sv - directed self-checking bench for controle_jogo_sequencia
module tb_controle_jogo_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       igual = 1'b0;
  logic       fim_contagem = 1'b0;
  logic       zera_contador, conta_contador, zera_registrador, registra;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;
  int n_conta = 0, n_reg = 0, n_zc = 0, n_zr = 0;

  controle_jogo_sequencia #(.TIMEOUT_CICLOS(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogada_feita    (jogada_feita),
    .igual           (igual),
    .fim_contagem    (fim_contagem),
    .zera_contador   (zera_contador),
    .conta_contador  (conta_contador),
    .zera_registrador(zera_registrador),
    .registra        (registra),
    .acertou         (acertou),
    .errou           (errou),
    .timeout         (timeout),
    .pronto          (pronto),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (conta_contador)   n_conta++;
    if (registra)         n_reg++;
    if (zera_contador)    n_zc++;
    if (zera_registrador) n_zr++;
  end

  function automatic logic [7:0] saidas();
    return {zera_contador, conta_contador, zera_registrador, registra,
            acertou, errou, timeout, pronto};
  endfunction

  task automatic do_play(input logic ig, input logic fc, output logic [3:0] res);
    @(negedge clock); jogada_feita = 1'b1;
    @(negedge clock); jogada_feita = 1'b0; igual = ig; fim_contagem = fc;
    @(negedge clock);
    @(negedge clock); res = db_estado; igual = 1'b0; fim_contagem = 1'b0;
    if (res == 4'h6) @(negedge clock);
  endtask

  task automatic test_reset();
    #2;
    total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL reset_state got=%h exp=0", db_estado); end
    total++; if (saidas() !== 8'h00) begin bad++; $display("FAIL reset_outputs got=%b exp=00000000", saidas()); end
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_start();
    int zc0, zr0;
    zc0 = n_zc; zr0 = n_zr;
    iniciar = 1'b1;
    @(negedge clock);
    total++; if (db_estado !== 4'h1) begin bad++; $display("FAIL start_prepara got=%h exp=1", db_estado); end
    total++; if (saidas() !== 8'b1010_0000) begin bad++; $display("FAIL start_prep_outputs got=%b exp=10100000", saidas()); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++; if (db_estado !== 4'h2) begin bad++; $display("FAIL start_espera[%0d] got=%h exp=2", i, db_estado); end
    end
    iniciar = 1'b0;
    total++; if (n_zc - zc0 !== 1) begin bad++; $display("FAIL start_zera_contador_pulses got=%0d exp=1", n_zc - zc0); end
    total++; if (n_zr - zr0 !== 1) begin bad++; $display("FAIL start_zera_registrador_pulses got=%0d exp=1", n_zr - zr0); end
  endtask

  task automatic test_win();
    int c0, r0;
    logic [3:0] r;
    c0 = n_conta; r0 = n_reg;
    for (int i = 0; i < 16; i++) begin
      do_play(1'b1, (i == 15), r);
      if (i < 15) begin
        total++; if (r !== 4'h6) begin bad++; $display("FAIL win_play[%0d] got=%h exp=6", i, r); end
      end
    end
    total++; if (db_estado !== 4'hA) begin bad++; $display("FAIL win_state got=%h exp=a", db_estado); end
    total++; if (saidas() !== 8'b0000_1001) begin bad++; $display("FAIL win_outputs got=%b exp=00001001", saidas()); end
    total++; if (n_conta - c0 !== 15) begin bad++; $display("FAIL win_conta_pulses got=%0d exp=15", n_conta - c0); end
    total++; if (n_reg - r0 !== 16) begin bad++; $display("FAIL win_registra_pulses got=%0d exp=16", n_reg - r0); end
  endtask

  task automatic test_ignore_in_fim();
    int r0;
    r0 = n_reg;
    jogada_feita = 1'b1;
    @(negedge clock); jogada_feita = 1'b0;
    total++; if (db_estado !== 4'hA) begin bad++; $display("FAIL fim_ignore_state1 got=%h exp=a", db_estado); end
    @(negedge clock);
    total++; if (db_estado !== 4'hA) begin bad++; $display("FAIL fim_ignore_state2 got=%h exp=a", db_estado); end
    total++; if (n_reg - r0 !== 0) begin bad++; $display("FAIL fim_ignore_registra got=%0d exp=0", n_reg - r0); end
  endtask

  task automatic test_error();
    int c0;
    logic [3:0] r;
    iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    total++; if (db_estado !== 4'h1) begin bad++; $display("FAIL err_restart got=%h exp=1", db_estado); end
    @(negedge clock);
    c0 = n_conta;
    for (int i = 0; i < 4; i++) do_play(1'b1, 1'b0, r);
    do_play(1'b0, 1'b0, r);
    total++; if (r !== 4'hE) begin bad++; $display("FAIL err_state got=%h exp=e", r); end
    total++; if (saidas() !== 8'b0000_0101) begin bad++; $display("FAIL err_outputs got=%b exp=00000101", saidas()); end
    total++; if (n_conta - c0 !== 4) begin bad++; $display("FAIL err_conta_pulses got=%0d exp=4", n_conta - c0); end
  endtask

  task automatic test_timeout();
    int n;
    logic [3:0] r;
    iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    total++; if (db_estado !== 4'h1) begin bad++; $display("FAIL to_restart got=%h exp=1", db_estado); end
    total++; if (saidas() !== 8'b1010_0000) begin bad++; $display("FAIL to_restart_outputs got=%b exp=10100000", saidas()); end
    @(negedge clock);
    do_play(1'b1, 1'b0, r);
    n = 1;
    for (int k = 0; k < 20 && db_estado == 4'h2; k++) begin
      @(negedge clock);
      if (db_estado == 4'h2) n++;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL to_espera_cycles got=%0d exp=8", n); end
    total++; if (db_estado !== 4'hD) begin bad++; $display("FAIL to_state got=%h exp=d", db_estado); end
    total++; if (saidas() !== 8'b0000_0111) begin bad++; $display("FAIL to_outputs got=%b exp=00000111", saidas()); end
  endtask

  task automatic test_timeout_race();
    int errs;
    errs = 0;
    iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (db_estado !== 4'h2) errs++;
      if (k == 8) jogada_feita = 1'b1;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL race_espera got=%0d_bad_cycles exp=0", errs); end
    @(negedge clock); jogada_feita = 1'b0; igual = 1'b1;
    total++; if (db_estado !== 4'h4) begin bad++; $display("FAIL race_registra got=%h exp=4", db_estado); end
    @(negedge clock);
    @(negedge clock); igual = 1'b0;
    total++; if (db_estado !== 4'h6) begin bad++; $display("FAIL race_proximo got=%h exp=6", db_estado); end
    @(negedge clock);
  endtask

  task automatic test_reset_in_compara();
    int c0;
    @(negedge clock); jogada_feita = 1'b1;
    @(negedge clock); jogada_feita = 1'b0; igual = 1'b1;
    @(negedge clock);
    total++; if (db_estado !== 4'h5) begin bad++; $display("FAIL rst_pre_compara got=%h exp=5", db_estado); end
    c0 = n_conta;
    #2 reset = 1'b1;
    #1;
    total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL rst_immediate got=%h exp=0", db_estado); end
    total++; if (saidas() !== 8'h00) begin bad++; $display("FAIL rst_outputs got=%b exp=00000000", saidas()); end
    @(negedge clock); reset = 1'b0; igual = 1'b0;
    @(negedge clock);
    total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL rst_hold got=%h exp=0", db_estado); end
    total++; if (n_conta - c0 !== 0) begin bad++; $display("FAIL rst_conta_pulse got=%0d exp=0", n_conta - c0); end
  endtask

  task automatic test_ignore_idle();
    int r0;
    r0 = n_reg;
    jogada_feita = 1'b1;
    @(negedge clock); jogada_feita = 1'b0;
    total++; if (db_estado !== 4'h0) begin bad++; $display("FAIL idle_inicial got=%h exp=0", db_estado); end
    iniciar = 1'b1; jogada_feita = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    total++; if (db_estado !== 4'h1) begin bad++; $display("FAIL idle_prepara got=%h exp=1", db_estado); end
    @(negedge clock); jogada_feita = 1'b0;
    total++; if (db_estado !== 4'h2) begin bad++; $display("FAIL idle_prep_exit got=%h exp=2", db_estado); end
    @(negedge clock);
    total++; if (db_estado !== 4'h2) begin bad++; $display("FAIL idle_espera_stay got=%h exp=2", db_estado); end
    total++; if (n_reg - r0 !== 0) begin bad++; $display("FAIL idle_registra got=%0d exp=0", n_reg - r0); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win();
    test_ignore_in_fim();
    test_error();
    test_timeout();
    test_timeout_race();
    test_reset_in_compara();
    test_ignore_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
